host_blob_packer: RTL

- Upstream neighbour of the host DMA write path.
- Gathers narrow per-element outputs from the last network layer into full host-bus-width beats, little-endian packed.
- Zero-pads the final partial beat of a blob and presents the beats on a valid/ready stream with a beat-aligned end-of-packet flag.
- The host write-back FIFO consumes this stream.

---
 rtl/host_blob_packer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/host_blob_packer.sv
// -----------------------------------------------------------------------------
// host_blob_packer
//
// Gathers narrow per-element results from the last network layer into
// full host-bus-width beats. Beats are packed little-endian, with element 0 in
// the least significant bits. They are presented on a valid/ready stream that
// feeds the host write-back FIFO.
//
// The final partial beat of a blob is zero-padded above the last element. That
// beat carries the end-of-packet flag, which is always beat-aligned.
//
// A 2-entry output FIFO with registered outputs decouples the element side
// from downstream backpressure. din_rdy depends only on registered occupancy,
// so there is no combinational path from blob_dout_rdy to din_rdy.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   din            in   element from the layer
//   din_en         in   element valid
//   din_eop        in   din is the last element of the blob (only with din_en)
//   din_rdy        out  packer accepts an element this cycle
//   blob_dout      out  packed beat (FIFO head)
//   blob_dout_en   out  beat valid (FIFO non-empty)
//   blob_dout_eop  out  head beat is the last beat of the blob
//   blob_dout_rdy  in   downstream accepts the beat this cycle
//   beat_cnt       out  beats transferred so far in the current blob
//   blob_done      out  one-cycle pulse after the eop beat transfers
// -----------------------------------------------------------------------------
module host_blob_packer #(
  parameter int ELEM_WIDTH         = 16,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int BEAT_CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ELEM_WIDTH-1:0]         din,
  input  logic                          din_en,
  input  logic                          din_eop,
  output logic                          din_rdy,
  output logic [C_M_AXI_DATA_WIDTH-1:0] blob_dout,
  output logic                          blob_dout_en,
  output logic                          blob_dout_eop,
  input  logic                          blob_dout_rdy,
  output logic [BEAT_CNT_WIDTH-1:0]     beat_cnt,
  output logic                          blob_done
);

  // Derived geometry. ELEMS_PER_BEAT follows from the two widths and is not
  // meant to be overridden.
  localparam int ELEMS_PER_BEAT = C_M_AXI_DATA_WIDTH / ELEM_WIDTH;
  localparam int IDX_W          = (ELEMS_PER_BEAT > 1) ? $clog2(ELEMS_PER_BEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS_PER_BEAT - 1);

  generate
    if ((C_M_AXI_DATA_WIDTH % ELEM_WIDTH) != 0) begin : g_bad_geometry
      $error("host_blob_packer: C_M_AXI_DATA_WIDTH must be a multiple of ELEM_WIDTH");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Assembly side
  // ---------------------------------------------------------------------------
  logic [C_M_AXI_DATA_WIDTH-1:0] asm_q, asm_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] push_word;
  logic                          accept;
  logic                          beat_last;
  logic                          push;

  // ---------------------------------------------------------------------------
  // Output FIFO: head entry drives the outputs directly, tail is the overflow
  // slot. occ_q counts valid entries (0..2).
  // ---------------------------------------------------------------------------
  logic [1:0]                    occ_q, occ_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] head_q, head_d;
  logic                          head_eop_q, head_eop_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] tail_q, tail_d;
  logic                          tail_eop_q, tail_eop_d;
  logic                          pop;

  // Counters
  logic [BEAT_CNT_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
  logic                          blob_done_q, blob_done_d;

  // Handshake decode. din_rdy is a pure function of registered occupancy, so a
  // push can only happen while at least one slot is free.
  assign din_rdy   = (occ_q != 2'd2);
  assign accept    = din_en && din_rdy;
  assign beat_last = (idx_q == LAST_IDX);
  assign push      = accept && (beat_last || din_eop);

  assign blob_dout_en = (occ_q != 2'd0);
  assign pop          = blob_dout_en && blob_dout_rdy;

  // Merge the incoming element into the partially assembled beat. Lanes below
  // the current index come from the assembly register, lane idx is din, and
  // everything above is forced to zero. This mask provides the zero padding
  // of a short final beat.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    push_word = '0;
    for (int i = 0; i < ELEMS_PER_BEAT; i++) begin
      if (IDX_W'(i) < idx_q) begin
        push_word[i*ELEM_WIDTH +: ELEM_WIDTH] = asm_q[i*ELEM_WIDTH +: ELEM_WIDTH];
      end else if (IDX_W'(i) == idx_q) begin
        push_word[i*ELEM_WIDTH +: ELEM_WIDTH] = din;
      end
    end
  end

  // Assembly register and lane index. A push restarts both in the same cycle,
  // so an element arriving on the next cycle lands in lane 0 of a clean beat.
  always_comb begin
    asm_d = asm_q;
    idx_d = idx_q;
    if (push) begin
      asm_d = '0;
      idx_d = '0;
    end else if (accept) begin
      asm_d = push_word;
      idx_d = idx_q + 1'b1;
    end
  end

  // FIFO next state. A push at occupancy 2 cannot occur because din_rdy is low
  // there, so that case only has to handle a pop.
  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    head_eop_d = head_eop_q;
    tail_d     = tail_q;
    tail_eop_d = tail_eop_q;
    unique case (occ_q)
      2'd0: begin
        if (push) begin
          head_d     = push_word;
          head_eop_d = din_eop;
          occ_d      = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // The head leaves and the new beat takes its place.
          head_d     = push_word;
          head_eop_d = din_eop;
        end else if (push) begin
          tail_d     = push_word;
          tail_eop_d = din_eop;
          occ_d      = 2'd2;
        end else if (pop) begin
          occ_d      = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d     = tail_q;
          head_eop_d = tail_eop_q;
          occ_d      = 2'd1;
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
  end

  // Transfer counters. beat_cnt counts the beats already delivered in this
  // blob and restarts when the eop beat leaves. blob_done marks that transfer
  // one cycle later.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    blob_done_d = 1'b0;
    if (pop) begin
      if (head_eop_q) begin
        beat_cnt_d  = '0;
        blob_done_d = 1'b1;
      end else begin
        beat_cnt_d  = beat_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q       <= '0;
      idx_q       <= '0;
      occ_q       <= 2'd0;
      // NOTE: the FIFO entries are reset even though occ_q alone marks them
      // invalid. The head drives blob_dout directly and must read zero after
      // reset. A reset also discards any half-built or queued beat of an
      // aborted blob.
      head_q      <= '0;
      head_eop_q  <= 1'b0;
      tail_q      <= '0;
      tail_eop_q  <= 1'b0;
      beat_cnt_q  <= '0;
      blob_done_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      idx_q       <= idx_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      head_eop_q  <= head_eop_d;
      tail_q      <= tail_d;
      tail_eop_q  <= tail_eop_d;
      beat_cnt_q  <= beat_cnt_d;
      blob_done_q <= blob_done_d;
    end
  end

  assign blob_dout     = head_q;
  assign blob_dout_eop = head_eop_q;
  assign beat_cnt      = beat_cnt_q;
  assign blob_done     = blob_done_q;

endmodule
